lawn_cursor_ctrl: RTL and testbench

LAWN_CURSOR_CTRL -- requirements
Module: lawn_cursor_ctrl

---
 rtl/lawn_cursor_if.sv | 16 +
 rtl/lawn_cursor_ctrl.sv | 90 +++++++++
 tb/tb_lawn_cursor_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lawn_cursor_if.sv
// lawn_cursor_if: raw buttons and level_clear in, cursor position, placement strobes and occupancy out.
interface lawn_cursor_if;
    logic upButton, downButton, leftButton, rightButton, selectButton, level_clear;
    logic isSelectingPlantBox, place_valid, place_reject;
    logic [1:0] plantSel;
    logic [2:0] lawnRow, lawnCol;
    logic [24:0] occupied;
    modport master(
        output upButton, downButton, leftButton, rightButton, selectButton, level_clear,
        input  isSelectingPlantBox, place_valid, place_reject, plantSel, lawnRow, lawnCol, occupied
    );
    modport slave(
        input  upButton, downButton, leftButton, rightButton, selectButton, level_clear,
        output isSelectingPlantBox, place_valid, place_reject, plantSel, lawnRow, lawnCol, occupied
    );
endinterface

// File: rtl/lawn_cursor_ctrl.sv
// lawn_cursor_ctrl: debounced button cursor for plant bar and 5x5 lawn with occupancy tracking.
// Define CURSOR_WRAP_EN to make cursor moves wrap at the edges instead of saturating.
module lawn_cursor_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input logic clk,
    input logic reset,
    lawn_cursor_if.slave bus
);
    typedef enum logic [1:0] {PICK_PLANT, PICK_CELL, PLACE} state_t;
    state_t state;
    logic [4:0] rawQ, level, levelQ, pressQ, ev;
    logic [19:0] cnt [5];
    logic [4:0] cellIdx;
    logic cellBusy;
    // button bit order is priority order: select, up, down, left, right; keep only the lowest set bit
    assign ev = pressQ & (~pressQ + 5'd1);
    assign cellIdx = 5'(bus.lawnRow) * 5'd5 + 5'(bus.lawnCol);
    assign cellBusy = bus.occupied[cellIdx];

    function automatic logic [2:0] step(input logic [2:0] v, input logic inc, input logic [2:0] mx);
`ifdef CURSOR_WRAP_EN
        return inc ? (v == mx ? 3'd0 : v + 3'd1) : (v == 3'd0 ? mx : v - 3'd1);
`else
        return inc ? (v == mx ? v : v + 3'd1) : (v == 3'd0 ? v : v - 3'd1);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            rawQ <= '0;
            level <= '0;
            levelQ <= '0;
            pressQ <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            rawQ <= {bus.rightButton, bus.leftButton, bus.downButton, bus.upButton, bus.selectButton};
            levelQ <= level;
            pressQ <= level & ~levelQ;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= (rawQ[i] != level[i] && cnt[i] != DEBOUNCE_CYCLES - 20'd1) ? cnt[i] + 20'd1 : '0;
                if (rawQ[i] != level[i] && cnt[i] == DEBOUNCE_CYCLES - 20'd1) level[i] <= rawQ[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= PICK_PLANT;
            bus.plantSel <= '0;
            bus.lawnRow <= '0;
            bus.lawnCol <= '0;
            bus.occupied <= '0;
            bus.place_valid <= 1'b0;
            bus.place_reject <= 1'b0;
            bus.isSelectingPlantBox <= 1'b1;
        end else begin
            bus.place_valid <= 1'b0;
            bus.place_reject <= 1'b0;
            if (bus.level_clear) begin
                state <= PICK_PLANT;
                bus.occupied <= '0;
                bus.isSelectingPlantBox <= 1'b1;
            end else begin
                case (state)
                    PICK_PLANT: begin
                        if (ev[0]) begin
                            state <= PICK_CELL;
                            bus.isSelectingPlantBox <= 1'b0;
                        end else if (ev[3] || ev[4]) bus.plantSel <= 2'(step({1'b0, bus.plantSel}, ev[4], 3'd2));
                    end
                    PICK_CELL: begin
                        if (ev[0] && cellBusy) bus.place_reject <= 1'b1;
                        else if (ev[0]) begin
                            state <= PLACE;
                            bus.place_valid <= 1'b1;
                        end else if (ev[1] || ev[2]) bus.lawnRow <= step(bus.lawnRow, ev[2], 3'd4);
                        else if (ev[3] || ev[4]) bus.lawnCol <= step(bus.lawnCol, ev[4], 3'd4);
                    end
                    default: begin
                        // PLACE (and any stray encoding) commits the cell and returns to the plant bar
                        bus.occupied[cellIdx] <= 1'b1;
                        state <= PICK_PLANT;
                        bus.isSelectingPlantBox <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lawn_cursor_ctrl.sv
// tb_lawn_cursor_ctrl: directed and random button presses checked against a behavioural cursor model.
module tb_lawn_cursor_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int mMode = 0, mSel = 0, mRow = 0, mCol = 0;
    logic [24:0] mOcc = '0;

    lawn_cursor_if bus();
    lawn_cursor_ctrl #(.DEBOUNCE_CYCLES(20'd4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_sel"}, 32'(bus.plantSel), 32'(mSel));
        check({tag, "_row"}, 32'(bus.lawnRow), 32'(mRow));
        check({tag, "_col"}, 32'(bus.lawnCol), 32'(mCol));
        check({tag, "_occ"}, 32'(bus.occupied), 32'(mOcc));
        check({tag, "_isSel"}, 32'(bus.isSelectingPlantBox), 32'(mMode == 0));
    endtask

    function automatic int mv(input int v, input int d, input int mx);
`ifdef CURSOR_WRAP_EN
        return (v + d + mx + 1) % (mx + 1);
`else
        return (v + d < 0 || v + d > mx) ? v : v + d;
`endif
    endfunction

    // b: 0 select, 1 up, 2 down, 3 left, 4 right; mode 0 = plant bar, 1 = lawn
    task automatic model(input int b, output int pv, output int pr);
        pv = 0;
        pr = 0;
        if (mMode == 0) begin
            if (b == 0) mMode = 1;
            else if (b == 3) mSel = mv(mSel, -1, 2);
            else if (b == 4) mSel = mv(mSel, 1, 2);
        end else if (b == 0) begin
            if (mOcc[mRow * 5 + mCol]) pr = 1;
            else begin
                pv = 1;
                mOcc[mRow * 5 + mCol] = 1'b1;
                mMode = 0;
            end
        end else if (b == 1) mRow = mv(mRow, -1, 4);
        else if (b == 2) mRow = mv(mRow, 1, 4);
        else if (b == 3) mCol = mv(mCol, -1, 4);
        else mCol = mv(mCol, 1, 4);
    endtask

    task automatic drive(input logic [4:0] m);
        bus.selectButton = m[0];
        bus.upButton = m[1];
        bus.downButton = m[2];
        bus.leftButton = m[3];
        bus.rightButton = m[4];
    endtask

    task automatic press(input logic [4:0] mask, input string tag);
        int b, pvN, prN, ePv, ePr, eSel, eRow, eCol;
        logic [31:0] cSel, cRow, cCol;
        b = 0; pvN = 0; prN = 0; cSel = 0; cRow = 0; cCol = 0;
        while (b < 4 && !mask[b]) b++;
        eSel = mSel; eRow = mRow; eCol = mCol;
        model(b, ePv, ePr);
        @(negedge clk);
        drive(mask);
        for (int k = 0; k < 26; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) drive(5'd0);
            if (bus.place_valid) begin
                pvN++;
                cSel = 32'(bus.plantSel);
                cRow = 32'(bus.lawnRow);
                cCol = 32'(bus.lawnCol);
            end
            if (bus.place_reject) prN++;
        end
        check({tag, "_pv"}, 32'(pvN), 32'(ePv));
        check({tag, "_pr"}, 32'(prN), 32'(ePr));
        if (ePv != 0) begin
            check({tag, "_pvSel"}, cSel, 32'(eSel));
            check({tag, "_pvRow"}, cRow, 32'(eRow));
            check({tag, "_pvCol"}, cCol, 32'(eCol));
        end
        check_all(tag);
    endtask

    task automatic goto_cell(input int r, input int c);
        if (mMode == 0) press(5'b00001, "go_sel");
        while (mRow > r) press(5'b00010, "go_up");
        while (mRow < r) press(5'b00100, "go_down");
        while (mCol > c) press(5'b01000, "go_left");
        while (mCol < c) press(5'b10000, "go_right");
    endtask

    initial begin
        logic [4:0] m;
        int rowBefore, seen;
        drive(5'd0);
        bus.level_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_pv", 32'(bus.place_valid), 32'd0);
        check("reset_pr", 32'(bus.place_reject), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // right held for exactly 4 samples: move lands 6 edges after the first high sample
        @(negedge clk);
        bus.rightButton = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) bus.rightButton = 1'b0;
            if (k == 6) check("rt_early", 32'(bus.plantSel), 32'd0);
            if (k == 7) check("rt_exact", 32'(bus.plantSel), 32'd1);
        end
        repeat (15) @(posedge clk);
        #1;
        mSel = 1;
        check_all("rt");

        @(negedge clk);
        bus.rightButton = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.rightButton = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_all("glitch");

        press(5'b01000, "left");
        press(5'b00001, "sel1");
        press(5'b00001, "place00");
        press(5'b00001, "sel2");
        press(5'b00001, "reject00");

        press(5'b00010, "up_edge");
`ifdef CURSOR_WRAP_EN
        check("up_edge_row", 32'(bus.lawnRow), 32'd4);
`else
        check("up_edge_row", 32'(bus.lawnRow), 32'd0);
`endif
        rowBefore = mRow;
        press(5'b00011, "up_sel");
        check("up_sel_row", 32'(bus.lawnRow), 32'(rowBefore));

        repeat (40) begin
            m = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) m = m | 5'(1 << $urandom_range(0, 4));
            press(m, "rnd");
        end

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (!mOcc[r * 5 + c]) begin
                    goto_cell(r, c);
                    press(5'b00001, "fill");
                end
        check("full_occ", 32'(bus.occupied), 32'h1FFFFFF);

        press(5'b00001, "lc_pre");
        @(negedge clk);
        bus.level_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.level_clear = 1'b0;
        mOcc = '0;
        mMode = 0;
        check("lc_pv", 32'(bus.place_valid), 32'd0);
        check_all("lc");

        // reset lands while the FSM sits in PLACE
        press(5'b00001, "rp_sel");
        seen = 0;
        @(negedge clk);
        drive(5'b00001);
        for (int k = 0; k < 26; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) drive(5'd0);
            if (seen == 1 && reset == 1'b0) reset = 1'b1;
            else if (bus.place_valid && seen == 0) begin
                seen = 1;
                reset = 1'b0;
            end
        end
        check("rp_seen", 32'(seen), 32'd1);
        mMode = 0; mSel = 0; mRow = 0; mCol = 0; mOcc = '0;
        check_all("rp");
        press(5'b10000, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
